multicycle_control_fsm: RTL and testbench

- Multicycle RV32I control unit; successor to the single-cycle decoder.
- Sequences each instruction over 3–5 states and drives a shared-memory datapath (PC, OldPC, IR, ALUOut, Data registers).
- Handshakes with the cache through mem_req/mem_ready and stretches any state for arbitrary miss latency.
- Adds the full branch set, the shift/xor/sltu ALU ops, a memory-wait timeout, and illegal-instruction trapping.

---
 rtl/multicycle_control_fsm.sv | 243 ++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control unit: sequences FETCH..writeback over a shared-memory datapath,
// stretches memory states on cache misses, and traps illegal instructions or wait timeouts.
// Optional macro STALL_CNT_EN adds the stall_cycles counter output.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 256,
    parameter int TO_W        = 9,
    parameter int BRANCH_EXT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    input  logic        lt,
    input  logic        ltu,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_read,
    output logic        mem_write,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [2:0]  imm_src,
    output logic [3:0]  alu_control,
    output logic        illegal_instr,
    output logic        mem_timeout
`ifdef STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2, S_TRAP
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [TO_W-1:0] r_waitCnt;
    logic            r_illegal;
    logic            r_timeout;
    logic [3:0]      w_aluFunc;
    logic            w_taken;
    logic            w_branchLegal;
    logic            w_waitExpired;
    logic            w_setIllegal;
    logic            w_setTimeout;

    // The limit cycle itself still accepts mem_ready; only a miss on it trips the trap.
    assign w_waitExpired = (MEM_TIMEOUT != 0) && !mem_ready &&
                           (r_waitCnt == TO_W'(MEM_TIMEOUT - 1));
    assign w_branchLegal = (funct3[2:1] == 2'b00) || (funct3[2] && (BRANCH_EXT != 0));

    always_comb begin
        w_aluFunc = 4'b0000;
        case (funct3)
            3'b000:  w_aluFunc = (r_state == S_EXECR && funct7b5) ? 4'b0001 : 4'b0000;
            3'b001:  w_aluFunc = 4'b0111;
            3'b010:  w_aluFunc = 4'b0101;
            3'b011:  w_aluFunc = 4'b0110;
            3'b100:  w_aluFunc = 4'b0100;
            3'b101:  w_aluFunc = funct7b5 ? 4'b1001 : 4'b1000;
            3'b110:  w_aluFunc = 4'b0011;
            default: w_aluFunc = 4'b0010;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (funct3)
            3'b000:  w_taken = zero;
            3'b001:  w_taken = !zero;
            3'b100:  w_taken = lt;
            3'b101:  w_taken = !lt;
            3'b110:  w_taken = ltu;
            3'b111:  w_taken = !ltu;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_nextState  = r_state;
        w_setIllegal = 1'b0;
        w_setTimeout = 1'b0;
        mem_req      = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        adr_src      = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        result_src   = 2'b00;
        imm_src      = 3'b000;
        alu_control  = 4'b0000;
        case (r_state)
            S_RST: w_nextState = S_FETCH;
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write    = 1'b1;
                    pc_write    = 1'b1;
                    alu_src_b   = 2'b10;
                    result_src  = 2'b10;
                    w_nextState = S_DECODE;
                end else if (w_waitExpired) begin
                    w_nextState  = S_TRAP;
                    w_setTimeout = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 3'b010;
                case (opcode)
                    7'b0000011, 7'b0100011: w_nextState = S_MEMADR;
                    7'b0110011: w_nextState = S_EXECR;
                    7'b0010011: w_nextState = S_EXECI;
                    7'b1100011: w_nextState = S_BRANCH;
                    7'b1101111: w_nextState = S_JAL;
                    7'b1100111: begin
                        if (funct3 == 3'b000) begin
                            w_nextState = S_JALR1;
                        end else begin
                            w_nextState  = S_TRAP;
                            w_setIllegal = 1'b1;
                        end
                    end
                    default: begin
                        w_nextState  = S_TRAP;
                        w_setIllegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                imm_src     = opcode[5] ? 3'b001 : 3'b000;
                w_nextState = opcode[5] ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                adr_src  = 1'b1;
                if (mem_ready) begin
                    w_nextState = S_MEMWB;
                end else if (w_waitExpired) begin
                    w_nextState  = S_TRAP;
                    w_setTimeout = 1'b1;
                end
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write   = 1'b1;
                w_nextState = S_FETCH;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) begin
                    w_nextState = S_FETCH;
                end else if (w_waitExpired) begin
                    w_nextState  = S_TRAP;
                    w_setTimeout = 1'b1;
                end
            end
            S_EXECR, S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = (r_state == S_EXECI) ? 2'b01 : 2'b00;
                alu_control = w_aluFunc;
                w_nextState = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write   = 1'b1;
                w_nextState = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = 4'b0001;
                if (w_branchLegal) begin
                    pc_write    = w_taken;
                    w_nextState = S_FETCH;
                end else begin
                    w_nextState  = S_TRAP;
                    w_setIllegal = 1'b1;
                end
            end
            S_JAL, S_JALR2: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b10;
                pc_write    = 1'b1;
                w_nextState = S_ALUWB;
            end
            S_JALR1: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                w_nextState = S_JALR2;
            end
            default: w_nextState = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_RST;
            r_waitCnt <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= (mem_req && !mem_ready) ? r_waitCnt + TO_W'(1) : '0;
            if (w_setIllegal) r_illegal <= 1'b1;
            if (w_setTimeout) r_timeout <= 1'b1;
        end
    end

    assign illegal_instr = r_illegal;
    assign mem_timeout   = r_timeout;

`ifdef STALL_CNT_EN
    logic [31:0] r_stallCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCnt <= '0;
        end else if (mem_req && !mem_ready) begin
            r_stallCnt <= r_stallCnt + 32'd1;
        end
    end

    assign stall_cycles = r_stallCnt;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: an instruction-level plan model predicts every
// cycle's control word for two instances (ext branches + timeout 4, and base branches + no timeout).
module tb_multicycle_control_fsm;

    typedef enum {
        P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR, P_EXEC,
        P_ALUWB, P_BRANCH, P_JAL, P_JALR1, P_JALR2, P_TRAP
    } step_t;

    typedef struct packed {
        logic ill, to, req, rd, wr, adr, irw, pcw, rw;
        logic [1:0] a, b, res;
        logic [2:0] imm;
        logic [3:0] alu;
    } ctrl_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       lt = 1'b0;
    logic       ltu = 1'b0;
    logic       mem_ready = 1'b1;
    wire [21:0] obsA;
    wire [21:0] obsB;
`ifdef STALL_CNT_EN
    wire [31:0] stallA;
    wire [31:0] stallB;
`endif

    int    nChecks = 0;
    int    nErrors = 0;
    int    sel = 0;
    int    expStall = 0;
    logic  expIll = 1'b0;
    logic  expTo = 1'b0;
    bit    abortInMemrd = 1'b0;
    bit    trapped;
    step_t plan[$];
    logic [6:0] opList [7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                               7'b1100011, 7'b1101111, 7'b1100111};

    always #5 clk = ~clk;

    multicycle_control_fsm #(.MEM_TIMEOUT(4), .TO_W(3), .BRANCH_EXT(1)) dutA (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .illegal_instr(obsA[21]), .mem_timeout(obsA[20]), .mem_req(obsA[19]),
        .mem_read(obsA[18]), .mem_write(obsA[17]), .adr_src(obsA[16]), .ir_write(obsA[15]),
        .pc_write(obsA[14]), .reg_write(obsA[13]), .alu_src_a(obsA[12:11]),
        .alu_src_b(obsA[10:9]), .result_src(obsA[8:7]), .imm_src(obsA[6:4]),
        .alu_control(obsA[3:0])
`ifdef STALL_CNT_EN
        , .stall_cycles(stallA)
`endif
    );

    multicycle_control_fsm #(.MEM_TIMEOUT(0), .TO_W(9), .BRANCH_EXT(0)) dutB (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .illegal_instr(obsB[21]), .mem_timeout(obsB[20]), .mem_req(obsB[19]),
        .mem_read(obsB[18]), .mem_write(obsB[17]), .adr_src(obsB[16]), .ir_write(obsB[15]),
        .pc_write(obsB[14]), .reg_write(obsB[13]), .alu_src_a(obsB[12:11]),
        .alu_src_b(obsB[10:9]), .result_src(obsB[8:7]), .imm_src(obsB[6:4]),
        .alu_control(obsB[3:0])
`ifdef STALL_CNT_EN
        , .stall_cycles(stallB)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: observed %h expected %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [3:0] aluFor(input logic isR, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0: return (isR && f7) ? 4'd1 : 4'd0;
            3'd1: return 4'd7;
            3'd2: return 4'd5;
            3'd3: return 4'd6;
            3'd4: return 4'd4;
            3'd5: return f7 ? 4'd9 : 4'd8;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic logic branchOk(input logic [2:0] f3);
        return (f3 <= 3'd1) || (f3 >= 3'd4 && sel == 0);
    endfunction

    function automatic logic branchTaken(input logic [2:0] f3);
        case (f3)
            3'd0: return zero;
            3'd1: return !zero;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return ltu;
            3'd7: return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    function automatic ctrl_t expectFor(input step_t s, input logic rdy);
        ctrl_t e;
        e = '0;
        e.ill = expIll;
        e.to  = expTo;
        case (s)
            P_FETCH: begin
                e.req = 1; e.rd = 1;
                if (rdy) begin e.irw = 1; e.pcw = 1; e.b = 2'b10; e.res = 2'b10; end
            end
            P_DECODE: begin e.a = 2'b01; e.b = 2'b01; e.imm = 3'b010; end
            P_MEMADR: begin
                e.a = 2'b10; e.b = 2'b01;
                e.imm = (opcode == 7'b0100011) ? 3'b001 : 3'b000;
            end
            P_MEMRD: begin e.req = 1; e.rd = 1; e.adr = 1; end
            P_MEMWB: begin e.res = 2'b01; e.rw = 1; end
            P_MEMWR: begin e.req = 1; e.wr = 1; e.adr = 1; end
            P_EXEC: begin
                e.a = 2'b10;
                e.b = (opcode == 7'b0110011) ? 2'b00 : 2'b01;
                e.alu = aluFor(opcode == 7'b0110011, funct3, funct7b5);
            end
            P_ALUWB: e.rw = 1;
            P_BRANCH: begin
                e.a = 2'b10; e.alu = 4'd1;
                e.pcw = branchOk(funct3) && branchTaken(funct3);
            end
            P_JAL, P_JALR2: begin e.a = 2'b01; e.b = 2'b10; e.pcw = 1; end
            P_JALR1: begin e.a = 2'b10; e.b = 2'b01; end
            default: e = e;
        endcase
        return e;
    endfunction

    task automatic fillPlan(output bit legal);
        plan.delete();
        legal = 1'b1;
        case (opcode)
            7'b0000011: begin plan.push_back(P_MEMADR); plan.push_back(P_MEMRD); plan.push_back(P_MEMWB); end
            7'b0100011: begin plan.push_back(P_MEMADR); plan.push_back(P_MEMWR); end
            7'b0110011, 7'b0010011: begin plan.push_back(P_EXEC); plan.push_back(P_ALUWB); end
            7'b1100011: plan.push_back(P_BRANCH);
            7'b1101111: begin plan.push_back(P_JAL); plan.push_back(P_ALUWB); end
            7'b1100111: begin
                if (funct3 == 3'd0) begin
                    plan.push_back(P_JALR1); plan.push_back(P_JALR2); plan.push_back(P_ALUWB);
                end else legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("resetHoldA", 32'(obsA), 32'd0);
        checkOutput("resetHoldB", 32'(obsB), 32'd0);
`ifdef STALL_CNT_EN
        checkOutput("resetStall", stallA, 32'd0);
`endif
        expIll = 1'b0;
        expTo = 1'b0;
        expStall = 0;
        rst_n = 1'b1;
        #1;
        checkOutput("rstState", 32'(sel != 0 ? obsB : obsA), 32'd0);
    endtask

    // Walks one instruction cycle by cycle; returns with trapped=1 after TRAP or an abort.
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input logic z, input logic l, input logic lu,
                                 input int fWait, input int mWait, output bit trp);
        step_t cur;
        int    cnt, trapSeen, limit;
        bit    rdy, legal, fin, first;
        ctrl_t e;
        cur = P_FETCH; cnt = 0; trapSeen = 0; fin = 0; first = 1; trp = 0;
        limit = (sel != 0) ? 0 : 4;
        while (!fin) begin
            @(negedge clk);
            if (first) begin
                opcode = op; funct3 = f3; funct7b5 = f7; zero = z; lt = l; ltu = lu;
                first = 0;
            end
            if (cur == P_FETCH || cur == P_MEMRD || cur == P_MEMWR)
                rdy = (cnt == ((cur == P_FETCH) ? fWait : mWait));
            else
                rdy = 1'($urandom_range(0, 1));
            mem_ready = rdy;
            #1;
            e = expectFor(cur, rdy);
            checkOutput(cur.name(), 32'(sel != 0 ? obsB : obsA), 32'(e));
            if (sel == 0 && e.req && !rdy) expStall++;
            if (cur == P_MEMRD && abortInMemrd) begin
                rst_n = 1'b0;
                #1;
                checkOutput("asyncReset", 32'(obsA), 32'd0);
                trp = 1;
                return;
            end
            case (cur)
                P_TRAP: begin
                    trapSeen++;
                    if (trapSeen == 2) begin fin = 1; trp = 1; end
                end
                P_FETCH, P_MEMRD, P_MEMWR: begin
                    if (rdy) begin
                        cnt = 0;
                        if (cur == P_FETCH) cur = P_DECODE;
                        else if (plan.size() == 0) fin = 1;
                        else cur = plan.pop_front();
                    end else begin
                        cnt++;
                        if (limit != 0 && cnt == limit) begin cur = P_TRAP; expTo = 1'b1; end
                    end
                end
                P_DECODE: begin
                    fillPlan(legal);
                    if (!legal) begin cur = P_TRAP; expIll = 1'b1; end
                    else cur = plan.pop_front();
                end
                default: begin
                    if (cur == P_BRANCH && !branchOk(funct3)) begin cur = P_TRAP; expIll = 1'b1; end
                    else if (plan.size() == 0) fin = 1;
                    else cur = plan.pop_front();
                end
            endcase
        end
`ifdef STALL_CNT_EN
        if (sel == 0 && !trp) checkOutput("stallCycles", stallA, 32'(expStall));
`endif
    endtask

    task automatic randomInstr(input int maxWait);
        logic [6:0] op;
        logic [2:0] f3;
        int fw, mw;
        op = opList[$urandom_range(0, 6)];
        if ($urandom_range(0, 9) == 0) op = 7'($urandom);
        f3 = 3'($urandom);
        if (op == 7'b1100111 && $urandom_range(0, 1) == 1) f3 = 3'd0;
        fw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, maxWait) : 0;
        mw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, maxWait) : 0;
        applyStimulus(op, f3, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), fw, mw, trapped);
        if (trapped) applyReset();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        sel = 0;
        applyReset();
        applyStimulus(7'b0110011, 3'd0, 0, 0, 0, 0, 0, 0, trapped);
        applyReset();
        applyStimulus(7'b0000011, 3'd2, 0, 0, 0, 0, 3, 3, trapped);
        applyStimulus(7'b1100011, 3'd5, 0, 0, 0, 0, 0, 0, trapped);
        applyStimulus(7'b1100011, 3'd5, 0, 0, 1, 0, 0, 0, trapped);
        applyStimulus(7'b0110011, 3'd0, 1, 0, 0, 0, 0, 0, trapped);
        applyStimulus(7'b0010011, 3'd5, 1, 0, 0, 0, 0, 0, trapped);
        applyStimulus(7'b0110011, 3'd3, 0, 0, 0, 0, 1, 0, trapped);
        applyStimulus(7'b1101111, 3'd0, 0, 0, 0, 0, 0, 0, trapped);
        applyStimulus(7'b1100111, 3'd0, 0, 0, 0, 0, 0, 0, trapped);
        applyStimulus(7'b0100011, 3'd2, 0, 0, 0, 0, 0, 0, trapped);
        applyStimulus(7'b0000000, 3'd0, 0, 0, 0, 0, 0, 0, trapped);
        applyReset();
        applyStimulus(7'b0100011, 3'd2, 0, 0, 0, 0, 0, 4, trapped);
        applyReset();
        applyStimulus(7'b0100011, 3'd2, 0, 0, 0, 0, 0, 3, trapped);
        applyStimulus(7'b0000011, 3'd2, 0, 0, 0, 0, 4, 0, trapped);
        applyReset();
        applyStimulus(7'b1100111, 3'd1, 0, 0, 0, 0, 0, 0, trapped);
        applyReset();
        abortInMemrd = 1'b1;
        applyStimulus(7'b0000011, 3'd2, 0, 0, 0, 0, 0, 2, trapped);
        abortInMemrd = 1'b0;
        applyReset();
        applyStimulus(7'b0110011, 3'd4, 0, 0, 0, 0, 0, 0, trapped);
        for (int n = 0; n < 150; n++) randomInstr(5);

        sel = 1;
        applyReset();
        applyStimulus(7'b1100011, 3'd4, 0, 0, 1, 0, 0, 0, trapped);
        applyReset();
        applyStimulus(7'b1100011, 3'd0, 0, 1, 0, 0, 0, 0, trapped);
        applyStimulus(7'b1100011, 3'd1, 0, 1, 0, 0, 0, 0, trapped);
        applyStimulus(7'b1100011, 3'd7, 0, 0, 0, 0, 0, 0, trapped);
        applyReset();
        applyStimulus(7'b0000011, 3'd2, 0, 0, 0, 0, 12, 7, trapped);
        for (int n = 0; n < 40; n++) randomInstr(8);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
